mm_arbiter: RTL and testbench

Round-robin scheduler that shares the operand-select datapath (`Mm` 6-bit select, 8-bit `result`) among `NREQ` requesters. Each requester hands over one 6-bit select code, M2M1M0 in [5:3] and m2m1m0 in [2:0]. The block drives that code onto the datapath's `Mm` input, waits the datapath latency, captures `result`, and returns it to the owning requester with a one-cycle response pulse. It sits between the requesting control logic and the existing operand-select/compute `Top` datapath, replacing the hand-driven `Mm` stimulus.

---
 rtl/mm_arbiter_pkg.sv | 12 +
 rtl/mm_arbiter_rr_picker.sv | 31 +++
 rtl/mm_arbiter.sv | 86 ++++++++
 tb/tb_mm_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_arbiter_pkg.sv
// Shared types and widths for the Mm operand-select arbiter.
package mm_arbiter_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int MM_W     = 6;
  localparam int DATA_W   = 8;
  localparam int MAX_NREQ = 8;
  localparam int CNT_W    = 3;
  localparam int IDX_W    = $clog2(MAX_NREQ);

endpackage

// File: rtl/mm_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr+1 (mod NREQ).
module rr_picker
  import mm_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Scan offsets 1..NREQ from the pointer so the last winner has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + i) % NREQ)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin scheduler sharing the Mm select / result datapath among NREQ requesters.
module mm_arbiter
  import mm_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DP_LATENCY = 1
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [MM_W*NREQ-1:0]   req_sel,
  output logic [NREQ-1:0]        req_ready,
  output logic [MM_W-1:0]        Mm,
  input  logic [DATA_W-1:0]      dp_result,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   busy
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pickIdx;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  pickGrant;
  logic [NREQ-1:0]  ownerOneHot;
  logic [MM_W-1:0]  pickSel;
  logic             handshake;

  rr_picker #(.NREQ(NREQ)) picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pickGrant),
    .idx   (pickIdx)
  );

  assign req_ready = (state == IDLE) ? pickGrant : '0;
  assign handshake = |(req_valid & req_ready);
  assign busy      = (state == WAIT);

  always_comb begin
    pickSel     = '0;
    ownerOneHot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pickGrant[j]) pickSel = req_sel[j*MM_W +: MM_W];
      if (int'(owner) == j) ownerOneHot[j] = 1'b1;
    end
  end

  // resp_valid defaults low so it can only pulse for the single cycle after completion.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= IDX_W'(NREQ - 1);
      owner      <= '0;
      cnt        <= '0;
      Mm         <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (handshake) begin
            Mm    <= pickSel;
            owner <= pickIdx;
            ptr   <= pickIdx;
            cnt   <= CNT_W'(DP_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_data  <= dp_result;
            resp_valid <= ownerOneHot;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// Scoreboard bench for mm_arbiter with a registered multiply datapath model.
module tb_mm_arbiter;
  import mm_arbiter_pkg::*;

  localparam int NREQ       = 4;
  localparam int DP_LATENCY = 1;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } resp_t;

  logic                 sysclk    = 1'b0;
  logic                 reset     = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [6*NREQ-1:0]    req_sel   = '0;
  logic [NREQ-1:0]      req_ready;
  logic [5:0]           Mm;
  logic [7:0]           dpResult  = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [7:0]           resp_data;
  logic                 busy;

  int        vectors     = 0;
  int        miscompares = 0;
  int        cycleCount  = 0;
  logic [NREQ-1:0] lastGrant;
  logic [NREQ-1:0] lastResp;
  int        expGrant[$];
  resp_t     expResp[$];

  mm_arbiter #(.NREQ(NREQ), .DP_LATENCY(DP_LATENCY)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .Mm         (Mm),
    .dp_result  (dpResult),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  // Datapath stand-in: result = I[Mm[5:3]] * I[Mm[2:0]] with I0..I7 = 1..8, one cycle late.
  always @(posedge sysclk)
    dpResult <= 8'((int'(Mm[5:3]) + 1) * (int'(Mm[2:0]) + 1));

  function automatic logic [NREQ-1:0] oneHot(input int k);
    logic [NREQ-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [5:0] sel);
    req_sel[k*6 +: 6] = sel;
    req_valid[k]      = 1'b1;
  endtask

  task automatic pushOp(input int k, input logic [7:0] data);
    resp_t r;
    r.owner = k;
    r.data  = data;
    expGrant.push_back(k);
    expResp.push_back(r);
  endtask

  // One clock: sample at the falling edge, then retire granted requests after the rising edge.
  task automatic cycle();
    @(negedge sysclk);
    lastGrant = req_valid & req_ready;
    lastResp  = resp_valid;
    cycleCount++;
    @(posedge sysclk);
    #1;
    req_valid = req_valid & ~lastGrant;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (n < budget && pending) begin
      cycle();
      n++;
      pending = (expGrant.size() != 0) || (expResp.size() != 0) || (req_valid != '0) || busy;
    end
    checkOutput({name, " completes"}, 32'(pending), 32'(0));
  endtask

  always @(negedge sysclk) begin
    logic [NREQ-1:0] g;
    int    e;
    resp_t r;
    if (!reset) begin
      g = req_valid & req_ready;
      if (g != '0) begin
        if (expGrant.size() == 0) checkOutput("unexpected grant", 32'(g), 32'(0));
        else begin
          e = expGrant.pop_front();
          checkOutput("grant owner", 32'(g), 32'(oneHot(e)));
        end
      end
      if (resp_valid != '0) begin
        if (expResp.size() == 0) checkOutput("unexpected resp", 32'(resp_valid), 32'(0));
        else begin
          r = expResp.pop_front();
          checkOutput("resp owner", 32'(resp_valid), 32'(oneHot(r.owner)));
          checkOutput("resp data", 32'(resp_data), 32'(r.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gc[$];
    logic seen;

    cycle();
    cycle();
    checkOutput("reset Mm", 32'(Mm), 32'(0));
    checkOutput("reset resp_data", 32'(resp_data), 32'(0));
    checkOutput("reset resp_valid", 32'(resp_valid), 32'(0));
    checkOutput("reset req_ready", 32'(req_ready), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    reset = 1'b0;
    cycle();

    // Full contention from reset: order 0,1,2,3 every three cycles.
    applyStimulus(0, 6'b010010); pushOp(0, 8'd9);
    applyStimulus(1, 6'b110110); pushOp(1, 8'd49);
    applyStimulus(2, 6'b001110); pushOp(2, 8'd14);
    applyStimulus(3, 6'b000111); pushOp(3, 8'd8);
    for (int n = 0; n < 40 && (expResp.size() != 0 || busy || req_valid != '0); n++) begin
      cycle();
      if (lastGrant != '0) gc.push_back(cycleCount);
    end
    checkOutput("contention grant count", 32'(gc.size()), 32'(4));
    for (int i = 1; i < gc.size(); i++)
      checkOutput("contention grant spacing", 32'(gc[i] - gc[i-1]), 32'(3));
    drain("contention", 20);

    // Pointer sits at 3, so requester 0 wins over 3.
    applyStimulus(0, 6'b010010);
    applyStimulus(3, 6'b000111);
    pushOp(0, 8'd9);
    pushOp(3, 8'd8);
    cycle();
    checkOutput("wrap first grant", 32'(lastGrant), 32'(4'b0001));
    drain("wrap", 20);

    // Same requester back to back: second grant coincides with first response.
    applyStimulus(1, 6'b110111); pushOp(1, 8'd56);
    cycle();
    checkOutput("b2b first grant", 32'(lastGrant), 32'(4'b0010));
    applyStimulus(1, 6'b110001); pushOp(1, 8'd14);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cycle();
      if (lastGrant != '0) begin
        seen = 1'b1;
        checkOutput("b2b second grant with resp", 32'(lastResp), 32'(4'b0010));
      end
    end
    checkOutput("b2b second grant seen", 32'(seen), 32'(1));
    drain("b2b", 20);

    // Single request with cycle-exact timing.
    applyStimulus(2, 6'b001001); pushOp(2, 8'd4);
    cycle();
    checkOutput("single grant", 32'(lastGrant), 32'(4'b0100));
    checkOutput("single Mm", 32'(Mm), 32'(6'b001001));
    checkOutput("single busy C+1", 32'(busy), 32'(1));
    cycle();
    checkOutput("single busy C+2", 32'(busy), 32'(1));
    checkOutput("single resp early", 32'(resp_valid), 32'(0));
    cycle();
    checkOutput("single busy C+3", 32'(busy), 32'(0));
    checkOutput("single resp_valid", 32'(resp_valid), 32'(4'b0100));
    checkOutput("single resp_data", 32'(resp_data), 32'(4));
    cycle();
    checkOutput("single resp pulse width", 32'(resp_valid), 32'(0));
    checkOutput("single Mm holds", 32'(Mm), 32'(6'b001001));
    drain("single", 10);

    // Reset the cycle after a grant: operation abandoned.
    applyStimulus(3, 6'b111000);
    expGrant.push_back(3);
    cycle();
    checkOutput("abandon grant", 32'(lastGrant), 32'(4'b1000));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("post-reset Mm", 32'(Mm), 32'(0));
    checkOutput("post-reset busy", 32'(busy), 32'(0));
    for (int n = 0; n < 4; n++) begin
      cycle();
      checkOutput("no resp after reset", 32'(lastResp), 32'(0));
    end
    applyStimulus(0, 6'b111110); pushOp(0, 8'd56);
    cycle();
    checkOutput("post-reset grant", 32'(lastGrant), 32'(4'b0001));
    checkOutput("post-reset new Mm", 32'(Mm), 32'(6'b111110));
    drain("post-reset", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
